// File: rtl/fifo_rd_framer_if.sv
// Pop-side FIFO and downstream valid/ready stream signals of the read framer.
// master = the framer, slave = FIFO plus downstream consumer.
interface fifo_rd_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_last,
    input  fifo_rd_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_last,
    output fifo_rd_data, fifo_empty, m_ready
  );
endinterface

// File: rtl/fifo_rd_framer.sv
// Drains a 1-cycle-latency FIFO pop port into a framed valid/ready stream through
// a 3-entry prefetch buffer; m_ready never reaches fifo_rd_en combinationally.
module fifo_rd_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_rd_framer_if.master      bus,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic [1:0]            buf_occ
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 buf_q [3];
  word_t                 buf_d [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  run_q, run_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic pop;
  logic valid;
  logic last;
  logic accept;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit rule: buffered plus in-flight words never exceed the 3 slots.
  always_comb begin
    pop    = run_q & ~bus.fifo_empty & (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);
    valid  = (occ_q != 2'd0);
    last   = valid & (word_idx_q == LAST_IDX);
    accept = valid & bus.m_ready;
  end

  // NOTE: combinational blocks use blocking '=' with defaults first; only the state register uses '<='.
  always_comb begin
    buf_d       = buf_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, accept};
    inflight_d  = pop;
    run_d       = 1'b1;
    word_idx_d  = word_idx_q;
    frame_cnt_d = frame_cnt_q;

    if (inflight_q) begin
      buf_d[tail_q] = bus.fifo_rd_data;
      tail_d        = ptr_inc(tail_q);
    end

    if (accept) begin
      head_d = ptr_inc(head_q);
      if (last) begin
        word_idx_d  = '0;
        frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
      end else begin
        word_idx_d  = word_idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: the buffer storage is reset too, so m_data reads 0 out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      run_q       <= 1'b0;
      word_idx_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      buf_q       <= buf_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      run_q       <= run_d;
      word_idx_q  <= word_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.m_valid    = valid;
  assign bus.m_data     = buf_q[head_q];
  assign bus.m_last     = last;
  assign frame_cnt      = frame_cnt_q;
  assign buf_occ        = occ_q;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Randomised scoreboard bench for fifo_rd_framer: a queue-based FIFO model feeds the
// DUT, expected words and frame markers are queued on load and checked on handshake.
module tb_fifo_rd_framer;

  localparam int DW        = 8;
  localparam int FRAME_LEN = 16;
  localparam int FCW       = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst1_n;

  fifo_rd_framer_if #(.DATA_WIDTH(DW)) bus ();
  fifo_rd_framer_if #(.DATA_WIDTH(DW)) bus1 ();

  logic [FCW-1:0] frame_cnt, frame_cnt1;
  logic [1:0]     buf_occ, buf_occ1;

  fifo_rd_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FRAME_LEN), .FCNT_WIDTH(FCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .frame_cnt (frame_cnt),
    .buf_occ   (buf_occ)
  );

  fifo_rd_framer #(.DATA_WIDTH(DW), .FRAME_LEN(1), .FCNT_WIDTH(FCW)) dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .bus       (bus1.master),
    .frame_cnt (frame_cnt1),
    .buf_occ   (buf_occ1)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q [$];
  exp_t          exp_q [$];
  int            model_cnt    = 0;
  int            model_frames = 0;
  int            pops_seen    = 0;
  int            ready_mode   = 1;   // 0: hold low, 1: hold high, 2: random
  bit            sparse       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each pushed word gets its frame position from a running count.
  task automatic load(input int n, input bit rnd, input int base);
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DW'($urandom) : DW'(base + i);
      l = ((model_cnt % FRAME_LEN) == FRAME_LEN - 1);
      src_q.push_back(d);
      exp_q.push_back('{data: d, last: l});
      if (l) model_frames++;
      model_cnt++;
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // FIFO model and stream-side driver for the main DUT.
  initial begin
    bit pop_s;
    bit phase;
    phase            = 1'b0;
    bus.fifo_rd_data = '0;
    bus.fifo_empty   = 1'b1;
    bus.m_ready      = 1'b1;
    forever begin
      @(negedge clk);
      pop_s = rst_n && bus.fifo_rd_en;
      if (pop_s) pops_seen++;
      if (rst_n && bus.fifo_empty) check("no_pop_when_empty", bus.fifo_rd_en, 0);
      @(posedge clk);
      #1;
      if (pop_s && rst_n && src_q.size() != 0) bus.fifo_rd_data = src_q.pop_front();
      phase          = ~phase;
      bus.fifo_empty = (src_q.size() == 0) || (sparse && phase);
      case (ready_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: pops on every handshake, and checks stalled outputs hold.
  initial begin
    exp_t e;
    exp_t held;
    bit   hold_pending;
    hold_pending = 1'b0;
    held         = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", bus.m_valid, 1);
          check("hold_data", bus.m_data, held.data);
          check("hold_last", bus.m_last, held.last);
        end
        hold_pending = 1'b0;
        if (bus.m_valid) begin
          if (bus.m_ready) begin
            check("scoreboard_has_word", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("m_data", bus.m_data, e.data);
              check("m_last", bus.m_last, e.last);
            end
          end else begin
            hold_pending = 1'b1;
            held         = '{data: bus.m_data, last: bus.m_last};
          end
        end
      end
    end
  end

  // FRAME_LEN=1 instance: feeds 4 counting words, every one must carry m_last.
  int rem1 = 4;
  int next1 = 0;
  int got1 = 0;
  initial begin
    bit pop1;
    rst1_n            = 1'b0;
    bus1.fifo_rd_data = '0;
    bus1.fifo_empty   = 1'b1;
    bus1.m_ready      = 1'b1;
    #32 rst1_n = 1'b1;
    forever begin
      @(negedge clk);
      pop1 = rst1_n && bus1.fifo_rd_en;
      if (bus1.m_valid && bus1.m_ready) begin
        check("fl1_data", bus1.m_data, got1);
        check("fl1_last", bus1.m_last, 1);
        got1++;
      end
      @(posedge clk);
      #1;
      if (pop1 && rem1 > 0) begin
        bus1.fifo_rd_data = DW'(next1);
        next1++;
        rem1--;
      end
      bus1.fifo_empty = (rem1 == 0);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;

    // Reset with a non-empty FIFO; then 0x00..0x1F streamed with m_ready=1.
    load(32, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_buf_occ", buf_occ, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rd_en_before_run", bus.fifo_rd_en, 0);
    @(negedge clk);
    check("first_pop", bus.fifo_rd_en, 1);
    @(negedge clk);
    check("valid_pop_plus_1", bus.m_valid, 0);
    @(negedge clk);
    check("valid_pop_plus_2", bus.m_valid, 1);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      check("stream_gapless", bus.m_valid, 1);
    end
    drain("stream_drain", 20);
    check("stream_frame_cnt", frame_cnt, 2);
    check("stream_idle_valid", bus.m_valid, 0);

    // Backpressure: m_ready low, plenty of FIFO data.
    @(posedge clk);
    #2;
    ready_mode = 0;
    pops_seen  = 0;
    load(16, 1'b0, 0);
    repeat (12) @(negedge clk);
    check("bp_pop_count", pops_seen, 3);
    check("bp_buf_occ", buf_occ, 3);
    check("bp_m_data", bus.m_data, 0);
    check("bp_m_valid", bus.m_valid, 1);
    @(posedge clk);
    #2 ready_mode = 1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bp_release_gapless", bus.m_valid, 1);
    end
    drain("bp_drain", 20);
    check("bp_frame_cnt", frame_cnt, FCW'(model_frames));

    // Sparse FIFO with random backpressure and random data.
    @(posedge clk);
    #2;
    sparse     = 1'b1;
    ready_mode = 2;
    load(40, 1'b1, 0);
    drain("sparse_drain", 2000);
    sparse     = 1'b0;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    check("sparse_frame_cnt", frame_cnt, FCW'(model_frames));

    // Mid-frame reset at word index 5 with two words buffered.
    @(posedge clk);
    #2 load(((FRAME_LEN - (model_cnt % FRAME_LEN)) % FRAME_LEN) + 5, 1'b1, 0);
    drain("pre_reset_drain", 200);
    @(posedge clk);
    #2;
    ready_mode = 0;
    load(4, 1'b1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (buf_occ != 2 && n < 20);
    check("pre_reset_occ2", buf_occ, 2);
    #1 rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    model_cnt    = 0;
    model_frames = 0;
    @(negedge clk);
    check("midrst_buf_occ", buf_occ, 0);
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_rd_en", bus.fifo_rd_en, 0);
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    ready_mode = 1;
    load(20, 1'b1, 0);
    drain("post_reset_drain", 200);
    check("post_reset_frame_cnt", frame_cnt, 1);

    // FRAME_LEN=1 instance finished long ago.
    check("fl1_words", got1, 4);
    check("fl1_frame_cnt", frame_cnt1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
